// File: rtl/irq_stack_sequencer.sv
// irq_stack_sequencer
// Takes over the SP/PC/CCR special ports of the register file for boot,
// interrupt entry and RTI. It stalls the pipeline, moves PC and CCR between
// the register file and the downward-growing data-memory stack as DATA_W
// words over a ready handshake, and then commits the new PC/SP/CCR in one cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   int_req                  interrupt request (a one-cycle pulse is enough)
//   rti_req                  RTI decoded, held by decode until the commit
//   pc_in, sp_in, ccr_in     live register values, captured on acceptance
//   mem_req/we/addr/wdata    data-memory request, held stable until mem_ready
//   mem_rdata, mem_ready     read data and completion (at the rising edge)
//   busy                     pipeline stall/flush
//   pc/sp/ccr_write, *_wdata one-cycle commit strobes and values
module irq_stack_sequencer #(
  parameter int unsigned DATA_W       = 16,
  parameter logic [31:0] RESET_VECTOR = 32'd0,
  parameter logic [31:0] INT_VECTOR   = 32'd2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              int_req,
  input  logic              rti_req,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       sp_in,
  input  logic [DATA_W-1:0] ccr_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              pc_write,
  output logic              sp_write,
  output logic              ccr_write,
  output logic [31:0]       pc_wdata,
  output logic [31:0]       sp_wdata,
  output logic [DATA_W-1:0] ccr_wdata
);

  typedef enum logic [3:0] {
    RST, BOOT_LO, BOOT_HI, IDLE, PUSH_HI, PUSH_LO, PUSH_CCR,
    VEC_LO, VEC_HI, POP_CCR, POP_LO, POP_HI, COMMIT
  } state_t;

  // Which sequence COMMIT is finishing.
  typedef enum logic [1:0] { MODE_BOOT, MODE_INT, MODE_RTI } mode_t;

  state_t state, state_n;
  mode_t  mode_q;

  logic              int_pending_q;
  logic [31:0]       sp_q, pc_q;
  logic [DATA_W-1:0] ccr_q, hi_q, lo_q, ccr_hold_q;

  logic accept_rti, accept_int;

  assign accept_rti = (state == IDLE) && rti_req;
  assign accept_int = (state == IDLE) && !rti_req && int_pending_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RST;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      RST:      state_n = BOOT_LO;
      BOOT_LO:  if (mem_ready) state_n = BOOT_HI;
      BOOT_HI:  if (mem_ready) state_n = COMMIT;
      IDLE: begin
        if (accept_rti)      state_n = POP_CCR;
        else if (accept_int) state_n = PUSH_HI;
      end
      PUSH_HI:  if (mem_ready) state_n = PUSH_LO;
      PUSH_LO:  if (mem_ready) state_n = PUSH_CCR;
      PUSH_CCR: if (mem_ready) state_n = VEC_LO;
      VEC_LO:   if (mem_ready) state_n = VEC_HI;
      VEC_HI:   if (mem_ready) state_n = COMMIT;
      POP_CCR:  if (mem_ready) state_n = POP_LO;
      POP_LO:   if (mem_ready) state_n = POP_HI;
      POP_HI:   if (mem_ready) state_n = COMMIT;
      COMMIT:   state_n = IDLE;
      default:  state_n = RST;
    endcase
  end

  // Captured operands, holding registers and the sticky interrupt flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q        <= MODE_BOOT;
      int_pending_q <= 1'b0;
      sp_q          <= '0;
      pc_q          <= '0;
      ccr_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      ccr_hold_q    <= '0;
    end else begin
      // A fresh pulse in the accept cycle is kept so it is not lost.
      int_pending_q <= int_req || (int_pending_q && !accept_int);
      if (accept_rti) begin
        mode_q <= MODE_RTI;
        sp_q   <= sp_in;
      end else if (accept_int) begin
        mode_q <= MODE_INT;
        sp_q   <= sp_in;
        pc_q   <= pc_in;
        ccr_q  <= ccr_in;
      end
      if (mem_ready) begin
        unique case (state)
          BOOT_LO, VEC_LO, POP_LO: lo_q       <= mem_rdata;
          BOOT_HI, VEC_HI, POP_HI: hi_q       <= mem_rdata;
          POP_CCR:                 ccr_hold_q <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

  // Outputs
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    pc_write  = 1'b0;
    sp_write  = 1'b0;
    ccr_write = 1'b0;
    pc_wdata  = '0;
    sp_wdata  = '0;
    ccr_wdata = '0;
    busy      = (state != IDLE) || rti_req || int_pending_q;
    unique case (state)
      BOOT_LO: begin mem_req = 1'b1; mem_addr = RESET_VECTOR; end
      BOOT_HI: begin mem_req = 1'b1; mem_addr = RESET_VECTOR + 32'd1; end
      PUSH_HI: begin
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = sp_q;
        mem_wdata = DATA_W'(pc_q[31:16]);
      end
      PUSH_LO: begin
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = sp_q - 32'd1;
        mem_wdata = DATA_W'(pc_q[15:0]);
      end
      PUSH_CCR: begin
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = sp_q - 32'd2;
        mem_wdata = ccr_q;
      end
      VEC_LO:  begin mem_req = 1'b1; mem_addr = INT_VECTOR; end
      VEC_HI:  begin mem_req = 1'b1; mem_addr = INT_VECTOR + 32'd1; end
      POP_CCR: begin mem_req = 1'b1; mem_addr = sp_q + 32'd1; end
      POP_LO:  begin mem_req = 1'b1; mem_addr = sp_q + 32'd2; end
      POP_HI:  begin mem_req = 1'b1; mem_addr = sp_q + 32'd3; end
      COMMIT: begin
        pc_write = 1'b1;
        pc_wdata = 32'({hi_q, lo_q});
        unique case (mode_q)
          MODE_INT: begin
            sp_write = 1'b1;
            sp_wdata = sp_q - 32'd3;
          end
          MODE_RTI: begin
            sp_write  = 1'b1;
            sp_wdata  = sp_q + 32'd3;
            ccr_write = 1'b1;
            ccr_wdata = ccr_hold_q;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_irq_stack_sequencer.sv
// Directed bench for irq_stack_sequencer: boot, INT entry, RTI, wait states,
// simultaneous RTI/INT requests and reset abort, against a word-addressed
// memory model with a programmable number of wait cycles per access.
module tb_irq_stack_sequencer;

  logic        clk, rst, int_req, rti_req;
  logic [31:0] pc_in, sp_in;
  logic [15:0] ccr_in;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        busy, pc_write, sp_write, ccr_write;
  logic [31:0] pc_wdata, sp_wdata;
  logic [15:0] ccr_wdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [15:0] mem [0:4095];
  int unsigned wait_states = 0;
  int unsigned wcnt = 0;

  // Handshake stability monitor
  logic        hold_valid = 1'b0;
  logic [31:0] hold_addr;
  logic [15:0] hold_wdata;
  logic        hold_we;
  int unsigned viol = 0;
  int unsigned wait_cycles = 0;

  irq_stack_sequencer #(
    .DATA_W(16), .RESET_VECTOR(32'd0), .INT_VECTOR(32'd2)
  ) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .rti_req(rti_req),
    .pc_in(pc_in), .sp_in(sp_in), .ccr_in(ccr_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .pc_write(pc_write), .sp_write(sp_write),
    .ccr_write(ccr_write), .pc_wdata(pc_wdata), .sp_wdata(sp_wdata),
    .ccr_wdata(ccr_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ready = mem_req && (wcnt >= wait_states);
  assign mem_rdata = mem[mem_addr[11:0]];

  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ready) mem[mem_addr[11:0]] = mem_wdata;
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
  end

  always @(posedge clk) begin
    if (hold_valid && mem_req &&
        (mem_addr !== hold_addr || mem_wdata !== hold_wdata || mem_we !== hold_we))
      viol <= viol + 1;
    if (hold_valid && !mem_req) viol <= viol + 1;
    hold_valid <= mem_req && !mem_ready;
    hold_addr  <= mem_addr;
    hold_wdata <= mem_wdata;
    hold_we    <= mem_we;
    if (mem_req && !mem_ready) wait_cycles <= wait_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int unsigned n;
  int unsigned int_commits;

  initial begin
    rst = 1'b1; int_req = 1'b0; rti_req = 1'b0;
    pc_in = '0; sp_in = '0; ccr_in = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[0] = 16'h0040; mem[1] = 16'h0001;
    mem[2] = 16'h0100; mem[3] = 16'h0000;

    // Reset state
    tick; tick;
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_strobes", {29'd0, pc_write, sp_write, ccr_write}, 32'd0);
    check("rst_pc_wdata", pc_wdata, 32'd0);

    // Boot
    rst = 1'b0;
    tick;
    check("boot_lo_addr", mem_addr, 32'd0);
    check("boot_lo_req", {31'd0, mem_req}, 32'd1);
    tick;
    check("boot_hi_addr", mem_addr, 32'd1);
    tick;
    check("boot_strobes", {29'd0, pc_write, sp_write, ccr_write}, 32'b100);
    check("boot_pc", pc_wdata, 32'h0001_0040);
    check("boot_commit_busy", {31'd0, busy}, 32'd1);
    tick;
    check("boot_idle_busy", {31'd0, busy}, 32'd0);

    // INT entry, mem_ready tied high
    sp_in = 32'd2047; pc_in = 32'h0001_2345; ccr_in = 16'h0005;
    int_req = 1'b1;
    tick;
    int_req = 1'b0;
    check("int_busy_c0", {31'd0, busy}, 32'd1);
    tick;
    sp_in = '0; pc_in = '0; ccr_in = '0;  // must already be captured
    check("push_hi", {mem_we, mem_addr[30:0]}, {1'b1, 31'd2047});
    check("push_hi_data", {16'd0, mem_wdata}, 32'h0001);
    tick;
    check("push_lo", {mem_we, mem_addr[30:0]}, {1'b1, 31'd2046});
    check("push_lo_data", {16'd0, mem_wdata}, 32'h2345);
    tick;
    check("push_ccr", {mem_we, mem_addr[30:0]}, {1'b1, 31'd2045});
    check("push_ccr_data", {16'd0, mem_wdata}, 32'h0005);
    tick;
    check("vec_lo", {mem_we, mem_addr[30:0]}, {1'b0, 31'd2});
    tick;
    check("vec_hi", {mem_we, mem_addr[30:0]}, {1'b0, 31'd3});
    tick;
    check("int_strobes", {29'd0, pc_write, sp_write, ccr_write}, 32'b110);
    check("int_pc", pc_wdata, 32'h0000_0100);
    check("int_sp", sp_wdata, 32'd2044);
    tick;
    check("int_idle_busy", {31'd0, busy}, 32'd0);
    check("int_stack", {mem[2047], mem[2046]}, 32'h0001_2345);
    check("int_stack_ccr", {16'd0, mem[2045]}, 32'h0005);

    // RTI
    sp_in = 32'd2044; rti_req = 1'b1;
    #1;
    check("rti_busy_c0", {31'd0, busy}, 32'd1);
    tick;
    sp_in = '0;
    check("pop_ccr", {mem_we, mem_addr[30:0]}, {1'b0, 31'd2045});
    tick;
    check("pop_lo", mem_addr, 32'd2046);
    tick;
    check("pop_hi", mem_addr, 32'd2047);
    tick;
    rti_req = 1'b0;
    check("rti_strobes", {29'd0, pc_write, sp_write, ccr_write}, 32'b111);
    check("rti_pc", pc_wdata, 32'h0001_2345);
    check("rti_ccr", {16'd0, ccr_wdata}, 32'h0005);
    check("rti_sp", sp_wdata, 32'd2047);
    tick;
    check("rti_idle_busy", {31'd0, busy}, 32'd0);

    // INT with 3 wait cycles per access
    wait_states = 3;
    sp_in = 32'd1000; pc_in = 32'hABCD_0123; ccr_in = 16'h00A5;
    int_req = 1'b1;
    tick;
    int_req = 1'b0;
    n = 0;
    while (!pc_write && n < 60) begin
      tick;
      n++;
    end
    check("ws_latency", n, 32'd21);
    check("ws_sp", sp_wdata, 32'd997);
    check("ws_pc", pc_wdata, 32'h0000_0100);
    check("ws_stable_viol", viol, 32'd0);
    check("ws_wait_cycles", wait_cycles, 32'd15);
    check("ws_stack", {mem[1000], mem[999]}, 32'hABCD_0123);
    check("ws_stack_ccr", {16'd0, mem[998]}, 32'h00A5);
    wait_states = 0;
    tick;

    // RTI and INT requested in the same IDLE cycle
    sp_in = 32'd997; pc_in = 32'h0000_7777; ccr_in = 16'h0011;
    rti_req = 1'b1; int_req = 1'b1;
    tick;
    int_req = 1'b0;
    check("both_rti_first", {mem_we, mem_addr[30:0]}, {1'b0, 31'd998});
    tick;
    int_req = 1'b1;  // extra pulse while busy
    tick;
    int_req = 1'b0;
    tick;
    rti_req = 1'b0;
    check("both_rti_strobes", {29'd0, pc_write, sp_write, ccr_write}, 32'b111);
    check("both_rti_pc", pc_wdata, 32'hABCD_0123);
    check("both_rti_sp", sp_wdata, 32'd1000);
    sp_in = 32'd1000;
    tick;
    check("both_idle_busy", {31'd0, busy}, 32'd1);
    check("both_idle_noreq", {31'd0, mem_req}, 32'd0);
    tick;
    check("both_int_push", {mem_we, mem_addr[30:0]}, {1'b1, 31'd1000});
    int_commits = 0;
    for (int i = 0; i < 30; i++) begin
      if (pc_write && sp_write && !ccr_write) int_commits++;
      tick;
    end
    check("both_int_once", int_commits, 32'd1);
    check("both_final_busy", {31'd0, busy}, 32'd0);

    // Reset during PUSH_LO
    sp_in = 32'd1500; pc_in = 32'h0000_BEEF; ccr_in = 16'h0033;
    int_req = 1'b1;
    tick;
    int_req = 1'b0;
    tick;
    tick;
    check("abort_in_push_lo", mem_addr, 32'd1499);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd1);
    check("abort_mem", {mem_req, mem_we, mem_addr[29:0]}, 32'd0);
    check("abort_wdata", {16'd0, mem_wdata}, 32'd0);
    int_commits = 0;
    for (int i = 0; i < 3; i++) begin
      if (pc_write || sp_write || ccr_write) int_commits++;
      tick;
    end
    check("abort_no_commit", int_commits, 32'd0);
    check("abort_no_write", {mem[1499], mem[1498]}, 32'd0);
    rst = 1'b0;
    tick; tick; tick;
    check("reboot_pc", pc_wdata, 32'h0001_0040);
    check("reboot_strobes", {29'd0, pc_write, sp_write, ccr_write}, 32'b100);
    tick;
    tick;
    check("reboot_pending_dropped", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_stack_sequencer.md
# irq_stack_sequencer

Multi-cycle sequencer that owns the SP/PC/CCR special ports of the register file during boot, interrupt entry and RTI. It stalls the pipeline, moves the 32-bit PC and 16-bit CCR to and from the data-memory stack as 16-bit words through a ready handshake, and then commits new PC/SP/CCR values in one cycle. It sits beside the decode/writeback stages. Its write strobes are ORed into the register file's sp_write, PC and CCR write paths.

## Interface
- DATA_W, 16, memory word and CCR width
- RESET_VECTOR, 32'd0, address of boot PC: low word at RESET_VECTOR, high word at RESET_VECTOR+1
- INT_VECTOR, 32'd2, address of ISR PC: low word at INT_VECTOR, high word at INT_VECTOR+1

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-high
- int_req  in  1  interrupt request; a one-cycle pulse is sufficient
- rti_req  in  1  RTI decoded; held by decode until busy drops
- pc_in  in  32  return PC, sampled when INT entry is accepted
- sp_in  in  32  current SP, sampled when any sequence is accepted
- ccr_in  in  DATA_W  current CCR, sampled when INT entry is accepted
- mem_req  out  1  memory access valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1
- mem_ready  in  1  access completes at this rising edge
- busy  out  1  stall/flush to the pipeline
- pc_write, sp_write, ccr_write  out  1 each  one-cycle commit strobes
- pc_wdata  out  32, sp_wdata  out  32, ccr_wdata  out  DATA_W  commit values

## Operation
- States: RST, BOOT_LO, BOOT_HI, IDLE, PUSH_HI, PUSH_LO, PUSH_CCR, VEC_LO, VEC_HI, POP_CCR, POP_LO, POP_HI, COMMIT.
- The stack grows downward. SP points at the next free word.
- Let S be the captured SP.
- INT entry:
  - Writes M[S] = pc[31:16], M[S-1] = pc[15:0], M[S-2] = CCR.
  - Reads the vector low word, then the high word.
  - COMMIT: pc_wdata = {hi, lo}, sp_wdata = S-3, pc_write = sp_write = 1, ccr_write = 0.
- RTI:
  - Reads CCR from M[S+1], PC low from M[S+2], PC high from M[S+3].
  - COMMIT: pc_write = sp_write = ccr_write = 1, sp_wdata = S+3.
- Boot:
  - Reads the PC low word, then the high word, from RESET_VECTOR.
  - COMMIT: pc_write only.
  - SP and CCR reset belong to the register file.
- SP arithmetic is modulo 2^32. Wrap at 0 is not detected.
- Vector address +1 is also modulo 2^32.
- int_req sets int_pending, a sticky flag. It is cleared when INT entry is accepted.
- int_req arriving while busy is latched. It is serviced on return to IDLE.
- IDLE acceptance:
  - If rti_req=1, the RTI sequence is accepted, even if int_pending=1. The pending interrupt waits for the next IDLE.
  - Otherwise, if int_pending=1, INT entry is accepted.
  - On acceptance, sp_in, pc_in and ccr_in are captured at that edge.
- Unread memory data is captured into hi/lo/ccr holding registers at the edge where mem_ready=1.

## Timing
- Reset values:
  - busy = 1.
  - All other outputs 0, including all strobes, mem_req, addresses and data.
  - State RST; int_pending = 0.
- Asserting rst mid-sequence aborts at once. No further memory access or commit occurs, and the pending interrupt is dropped.
- First rising edge after rst falls: RST -> BOOT_LO.
- Every memory state holds mem_req=1 with stable addr/we/wdata. It advances only on an edge with mem_ready=1. Any number of wait cycles is allowed.
- mem_req is 0 in IDLE, COMMIT and RST.
- COMMIT lasts exactly one cycle, then the state goes to IDLE.
  - Strobes are high only in COMMIT.
  - busy stays high through COMMIT.
- busy = (state != IDLE) OR (state == IDLE AND (rti_req OR int_pending)). That is, busy rises combinationally in the accept cycle.
- Latency with mem_ready tied high, where the request is seen in IDLE at cycle 0:
  - INT: COMMIT at cycle 6, IDLE at cycle 7.
  - RTI: COMMIT at cycle 4, IDLE at cycle 5.
  - Boot: COMMIT 3 cycles after the first edge following reset release.
- An int_req pulse during COMMIT is latched. The next IDLE cycle shows busy=1, and INT is accepted at the edge that follows.

## Test plan
- Boot: M[0]=0x0040, M[1]=0x0001, mem_ready=1, release rst -> 3 cycles later pc_write=1 with pc_wdata=0x00010040, then busy=0.
- INT: sp_in=2047, pc_in=0x00012345, ccr_in=0x0005, M[2]=0x0100, M[3]=0 -> writes 0x0001@2047, 0x2345@2046, 0x0005@2045; commit pc=0x00000100, sp=2044; 7 cycles total.
- RTI after INT: sp_in=2044 -> reads 2045, 2046, 2047; commit pc=0x00012345, ccr=0x0005, sp=2047.
- Wait states: 3-cycle mem_ready delay per access during INT -> addr/wdata held stable, commit at cycle 6+5*3=21.
- rti_req and int_req in the same IDLE cycle -> RTI runs first, then INT starts on the IDLE cycle after RTI's COMMIT; an int_req pulse during busy is serviced exactly once.
- rst asserted during PUSH_LO -> outputs 0 and busy=1 immediately, no commit; boot sequence reruns after release.
